uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 119 +++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, LSB-first 8N1-style frame.
// Latency: done/frame_err pulse one cycle after the mid-stop sample; no backpressure, new frames overwrite data.
module uart_rx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_en,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  done,
   output logic                  busy,
   output logic                  frame_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'((CLKS_PER_BIT >> 1) - 1);
   localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                state;
   state_t                state_next;
   logic                  rx_meta;
   logic                  rx_s;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      bit_idx;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  half_tick;
   logic                  full_tick;

   // Both flops reset high so a reset never looks like a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   assign half_tick = (cnt == HALF_M1);
   assign full_tick = (cnt == FULL_M1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (rx_en && !rx_s) state_next = START;
         START: if (half_tick) state_next = rx_s ? IDLE : DATA;
         DATA:  if (full_tick && (bit_idx == LAST_IDX)) state_next = STOP;
         STOP:  if (full_tick) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   // Counter restarts on every state change and at each full-bit sample inside DATA.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         data      <= '0;
         done      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         done      <= 1'b0;
         frame_err <= 1'b0;
         if ((state_next != state) || full_tick) begin
            cnt <= '0;
         end else if (state != IDLE) begin
            cnt <= cnt + CNT_W'(1);
         end
         case (state)
            START: begin
               if (half_tick && !rx_s) bit_idx <= '0;
            end
            DATA: begin
               if (full_tick) begin
                  shreg[bit_idx] <= rx_s;
                  bit_idx        <= bit_idx + IDX_W'(1);
               end
            end
            STOP: begin
               if (full_tick) begin
                  if (rx_s) begin
                     data <= shreg;
                     done <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLKS_PER_BIT=16: directed frames, scoreboard of expected done/frame_err pulses.
module tb_uart_rx;

   localparam int DW  = 8;
   localparam int CPB = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_en;
   logic          rx;
   logic [DW-1:0] data;
   logic          done;
   logic          busy;
   logic          frame_err;

   typedef struct {
      bit            is_err;
      logic [DW-1:0] dat;
      int            gap;
   } exp_t;

   exp_t sb[$];
   int   checks        = 0;
   int   failures      = 0;
   int   cyc           = 0;
   int   last_done_cyc = -1;
   int   busy_cycles   = 0;

   always #5 clk = ~clk;

   uart_rx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_en     (rx_en),
      .rx        (rx),
      .data      (data),
      .done      (done),
      .busy      (busy),
      .frame_err (frame_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done/frame_err pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (busy) busy_cycles++;
      if (!rst && (done || frame_err)) begin
         check("done_err_exclusive", {31'b0, done & frame_err}, 32'd0);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: done=%0b frame_err=%0b data=%0h with nothing expected (cycle %0d)",
                     done, frame_err, data, cyc);
         end else begin
            e = sb.pop_front();
            check("pulse_kind_frame_err", {31'b0, frame_err}, {31'b0, e.is_err});
            check("pulse_data", {24'b0, data}, {24'b0, e.dat});
            if (e.gap > 0) check("done_gap", cyc - last_done_cyc, e.gap);
         end
         if (done) last_done_cyc = cyc;
      end
   end

   task automatic push(input bit is_err, input logic [DW-1:0] d, input int gap);
      exp_t e;
      e.is_err = is_err;
      e.dat    = d;
      e.gap    = gap;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [DW-1:0] b, input bit stop, input bit chk_busy, input int drop_en_bit);
      logic [DW+1:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < DW + 2; i++) begin
         rx = fr[i];
         if (drop_en_bit >= 0 && i == drop_en_bit + 1) rx_en = 1'b0;
         for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            if (chk_busy && c == CPB / 2 && i >= 1 && i <= DW)
               check("busy_in_frame", {31'b0, busy}, 32'd1);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data"}, {24'b0, data}, 32'd0);
      check({tag, "_done"}, {31'b0, done}, 32'd0);
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
      check({tag, "_frame_err"}, {31'b0, frame_err}, 32'd0);
   endtask

   initial begin
      logic [DW+1:0] fr;
      rst   = 1'b1;
      rx    = 1'b1;
      rx_en = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      idle(20);

      // Single good frame with busy checked at every data-bit midpoint.
      push(1'b0, 8'hA5, 0);
      send(8'hA5, 1'b1, 1'b1, -1);
      idle(20);
      check("data_a5", {24'b0, data}, 32'h0000_00A5);

      // Back-to-back frames, no idle gap: done pulses one frame length apart.
      push(1'b0, 8'h00, 0);
      push(1'b0, 8'hFF, 10 * CPB);
      send(8'h00, 1'b1, 1'b0, -1);
      send(8'hFF, 1'b1, 1'b0, -1);
      idle(20);

      // Bad stop bit: frame_err, data held, then a good frame.
      push(1'b1, 8'hFF, 0);
      send(8'h3C, 1'b0, 1'b0, -1);
      idle(40);
      check("data_held_after_ferr", {24'b0, data}, 32'h0000_00FF);
      push(1'b0, 8'h81, 0);
      send(8'h81, 1'b1, 1'b0, -1);
      idle(20);

      // Short low glitch while idle.
      busy_cycles = 0;
      rx = 1'b0;
      repeat (5) @(negedge clk);
      idle(30);
      check("glitch_busy_1_to_9", {31'b0, (busy_cycles >= 1 && busy_cycles <= 9)}, 32'd1);
      check("glitch_data_kept", {24'b0, data}, 32'h0000_0081);

      // Reset in the middle of bit 4 of 0x5A.
      fr = {1'b1, 8'h5A, 1'b0};
      for (int i = 0; i <= 4; i++) begin
         rx = fr[i];
         repeat ((i == 4) ? CPB / 2 : CPB) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("midframe_rst");
      rst = 1'b0;
      idle(40);
      push(1'b0, 8'h5A, 0);
      send(8'h5A, 1'b1, 1'b0, -1);
      idle(20);

      // Receiver disabled: nothing happens.
      rx_en = 1'b0;
      busy_cycles = 0;
      send(8'h77, 1'b1, 1'b0, -1);
      idle(20);
      check("disabled_busy_cycles", busy_cycles, 32'd0);
      check("disabled_data_kept", {24'b0, data}, 32'h0000_005A);

      // Enable dropped mid-frame: frame still completes.
      rx_en = 1'b1;
      push(1'b0, 8'h77, 0);
      send(8'h77, 1'b1, 1'b0, 2);
      idle(20);
      check("en_drop_data", {24'b0, data}, 32'h0000_0077);
      rx_en = 1'b1;

      for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
